// File: rtl/dqsw_delay_trainer_if.sv
// Sequencer + per-lane IOD signal bundle for dqsw_delay_trainer.
// slave = trainer side; master = training sequencer / IOD side.
interface dqsw_delay_trainer_if #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 7
);
    logic                       START;
    logic [NUM_LANES-1:0]       LANE_MASK;
    logic                       BUSY;
    logic                       DONE;
    logic [NUM_LANES-1:0]       LANE_FAIL;
    logic [NUM_LANES*TAP_W-1:0] TAP_VALUE;
    logic [NUM_LANES-1:0]       DELAY_LINE_LOAD;
    logic [NUM_LANES-1:0]       DELAY_LINE_MOVE;
    logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION;
    logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS;
    logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY;
    logic [NUM_LANES-1:0]       EYE_MONITOR_LATE;
    logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE;

    modport slave (
        input  START, LANE_MASK, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        output BUSY, DONE, LANE_FAIL, TAP_VALUE, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
               DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
    );

    modport master (
        output START, LANE_MASK, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        input  BUSY, DONE, LANE_FAIL, TAP_VALUE, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
               DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
    );
endinterface

// File: rtl/dqsw_delay_trainer.sv
// Multi-lane DQSW delay-line trainer: sweeps each lane up to the LATE edge, backs off, reports taps.
// Optional macro DQSW_TRAIN_MAJORITY_EN: three sample windows per tap, LATE needs 2 of 3 votes.

module dqsw_lane_slot #(
    parameter int TAP_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             load,
    input  logic             move,
    input  logic             dir,
    input  logic             clr_flags,
    input  logic             res_clr,
    input  logic             res_wr,
    input  logic             res_fail,
    input  logic [TAP_W-1:0] res_tap,
    output logic             dl_load,
    output logic             dl_move,
    output logic             dl_dir,
    output logic             em_clr,
    output logic             lane_fail,
    output logic [TAP_W-1:0] tap_value
);
    // Only the selected lane sees the shared FSM controls; the rest stay at 0.
    assign dl_load = sel & load;
    assign dl_move = sel & move;
    assign dl_dir  = sel & dir;
    assign em_clr  = sel & clr_flags;

    always_ff @(posedge clk) begin
        if (rst || res_clr) begin
            lane_fail <= 1'b0;
            tap_value <= '0;
        end else if (sel && res_wr) begin
            lane_fail <= res_fail;
            tap_value <= res_tap;
        end
    end
endmodule

module dqsw_delay_trainer #(
    parameter int NUM_LANES     = 4,
    parameter int TAP_W         = 7,
    parameter int MAX_TAPS      = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int BACKOFF       = 4
) (
    input logic                 FAB_CLK,
    input logic                 SYNC_RST,
    dqsw_delay_trainer_if.slave bus
);
    localparam int LW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int VW      = 2;
`ifdef DQSW_TRAIN_MAJORITY_EN
    localparam int WINDOWS    = 3;
    localparam int LATE_VOTES = 2;
`else
    localparam int WINDOWS    = 1;
    localparam int LATE_VOTES = 1;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_SELECT, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_EVAL,
        S_MOVE, S_BACKOFF, S_BK_SETTLE, S_NEXT, S_FIN
    } state_t;

    state_t               state, state_nx;
    logic [LW-1:0]        lane;
    logic [NUM_LANES-1:0] mask_q;
    logic [TAP_W-1:0]     tap;
    logic [TAP_W-1:0]     bk_left;
    logic [CW-1:0]        cnt;
    logic [VW-1:0]        win;
    logic [VW-1:0]        late_votes;
    logic                 oor_seen;
    logic                 late_stk;
    logic                 oor_stk;

    logic late_now, oor_now, settle_done, sample_done, last_win;
    logic edge_found, at_max, last_lane, go_move;
    logic ctl_load, ctl_move, ctl_dir, ctl_clr, busy, done;
    logic res_clr, res_wr, res_fail;
    logic early_unused;

    // EARLY is advisory only: it never marks the edge.
    assign early_unused = |bus.EYE_MONITOR_EARLY;

    assign late_now    = late_stk | bus.EYE_MONITOR_LATE[lane];
    assign oor_now     = oor_stk  | bus.DELAY_LINE_OUT_OF_RANGE[lane];
    assign settle_done = (cnt == CW'(SETTLE_CYCLES - 1));
    assign sample_done = (cnt == CW'(SAMPLE_CYCLES - 1));
    assign last_win    = (win == VW'(WINDOWS - 1));
    assign edge_found  = (late_votes >= VW'(LATE_VOTES));
    assign at_max      = (tap == TAP_W'(MAX_TAPS));
    assign last_lane   = (lane == LW'(NUM_LANES - 1));
    assign go_move     = !oor_seen && !edge_found && !at_max;

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (bus.START) state_nx = S_SELECT;
            S_SELECT:    state_nx = mask_q[lane] ? S_LOAD : S_NEXT;
            S_LOAD:      state_nx = S_SETTLE;
            S_SETTLE:    if (settle_done) state_nx = S_CLEAR;
            S_CLEAR:     state_nx = S_SAMPLE;
            S_SAMPLE:    if (sample_done) state_nx = last_win ? S_EVAL : S_CLEAR;
            S_EVAL: begin
                if (oor_seen)        state_nx = S_NEXT;
                else if (edge_found) state_nx = S_BACKOFF;
                else if (at_max)     state_nx = S_NEXT;
                else                 state_nx = S_MOVE;
            end
            S_MOVE:      state_nx = S_SETTLE;
            S_BACKOFF:   state_nx = (bk_left == '0) ? S_NEXT : S_BK_SETTLE;
            S_BK_SETTLE: if (settle_done) state_nx = S_BACKOFF;
            S_NEXT:      state_nx = last_lane ? S_FIN : S_SELECT;
            S_FIN:       state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Increment direction is raised in the deciding EVAL cycle so it leads MOVE by one cycle;
    // decrement direction (0) is already the idle level before every backoff pulse.
    always_comb begin
        ctl_load = (state == S_LOAD);
        ctl_move = (state == S_MOVE) || (state == S_BACKOFF && bk_left != '0);
        ctl_dir  = (state == S_MOVE) || (state == S_EVAL && go_move);
        ctl_clr  = (state == S_CLEAR);
        busy     = (state != S_IDLE) && (state != S_FIN);
        done     = (state == S_FIN);
        res_clr  = (state == S_IDLE) && bus.START;
        res_wr   = ((state == S_EVAL) && (oor_seen || (!edge_found && at_max))) ||
                   ((state == S_BACKOFF) && (bk_left == '0));
        res_fail = (state == S_EVAL);
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            lane       <= '0;
            mask_q     <= '0;
            tap        <= '0;
            bk_left    <= '0;
            cnt        <= '0;
            win        <= '0;
            late_votes <= '0;
            oor_seen   <= 1'b0;
            late_stk   <= 1'b0;
            oor_stk    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.START) begin
                    mask_q <= bus.LANE_MASK;
                    lane   <= '0;
                end
                S_LOAD, S_MOVE: begin
                    tap        <= (state == S_LOAD) ? '0 : tap + 1'b1;
                    cnt        <= '0;
                    win        <= '0;
                    late_votes <= '0;
                    oor_seen   <= 1'b0;
                end
                S_SETTLE, S_BK_SETTLE: cnt <= cnt + 1'b1;
                S_CLEAR: begin
                    cnt      <= '0;
                    late_stk <= 1'b0;
                    oor_stk  <= 1'b0;
                end
                S_SAMPLE: begin
                    late_stk <= late_now;
                    oor_stk  <= oor_now;
                    cnt      <= cnt + 1'b1;
                    if (sample_done) begin
                        late_votes <= late_votes + VW'(late_now);
                        oor_seen   <= oor_seen | oor_now;
                        win        <= last_win ? '0 : win + 1'b1;
                    end
                end
                S_EVAL: if (!oor_seen && edge_found)
                    bk_left <= (tap < TAP_W'(BACKOFF)) ? tap : TAP_W'(BACKOFF);
                S_BACKOFF: begin
                    cnt <= '0;
                    if (bk_left != '0) begin
                        tap     <= tap - 1'b1;
                        bk_left <= bk_left - 1'b1;
                    end
                end
                S_NEXT: if (!last_lane) lane <= lane + 1'b1;
                default: ;
            endcase
        end
    end

    logic [NUM_LANES-1:0]            dl_load, dl_move, dl_dir, em_clr, lane_fail;
    logic [NUM_LANES-1:0][TAP_W-1:0] tap_value;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dqsw_lane_slot #(.TAP_W(TAP_W)) u_slot (
            .clk       (FAB_CLK),
            .rst       (SYNC_RST),
            .sel       (lane == LW'(i)),
            .load      (ctl_load),
            .move      (ctl_move),
            .dir       (ctl_dir),
            .clr_flags (ctl_clr),
            .res_clr   (res_clr),
            .res_wr    (res_wr),
            .res_fail  (res_fail),
            .res_tap   (tap),
            .dl_load   (dl_load[i]),
            .dl_move   (dl_move[i]),
            .dl_dir    (dl_dir[i]),
            .em_clr    (em_clr[i]),
            .lane_fail (lane_fail[i]),
            .tap_value (tap_value[i])
        );
    end

    assign bus.BUSY                    = busy;
    assign bus.DONE                    = done;
    assign bus.LANE_FAIL               = lane_fail;
    assign bus.TAP_VALUE               = tap_value;
    assign bus.DELAY_LINE_LOAD         = dl_load;
    assign bus.DELAY_LINE_MOVE         = dl_move;
    assign bus.DELAY_LINE_DIRECTION    = dl_dir;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = em_clr;
endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// Bench for dqsw_delay_trainer: directed table, reset abort sequence and random lanes,
// with an IOD/eye behavioural model and a tap-sweep reference computed per lane.
module tb_dqsw_delay_trainer;
    localparam int NL = 4, TW = 7, MT = 127, SC = 8, PC = 16, BK = 4, NEVER = 255;
`ifdef DQSW_TRAIN_MAJORITY_EN
    localparam int WIN = 3, THR = 2;
`else
    localparam int WIN = 1, THR = 1;
`endif

    typedef struct {
        string              name;
        logic [NL-1:0]      mask;
        logic [NL-1:0][7:0] late_at;
        logic [NL-1:0][7:0] oor_at;
        logic [NL-1:0][7:0] glitch_at;
        logic [NL-1:0][7:0] exp_tap;
        logic [NL-1:0]      exp_fail;
        bit                 noise;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dqsw_delay_trainer_if #(.NUM_LANES(NL), .TAP_W(TW)) dif ();

    dqsw_delay_trainer #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAPS(MT),
        .SETTLE_CYCLES(SC), .SAMPLE_CYCLES(PC), .BACKOFF(BK)
    ) dut (
        .FAB_CLK  (clk),
        .SYNC_RST (rst),
        .bus      (dif)
    );

    int n_chk = 0, n_pass = 0;
    int late_a[NL], oor_a[NL], glitch_a[NL];
    int pos[NL], win_idx[NL], last_lm[NL];
    int n_load[NL], n_inc[NL], n_dec[NL], n_clr[NL];
    int viol = 0, cyc = 0;
    logic [NL-1:0] dir_prev = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference: walk taps upward applying the EVAL priority rules directly.
    function automatic void model_lane(input bit m, input int la, input int oa, input int ga,
                                       output int tap, output bit fail, output int nt, output int nd);
        int votes;
        tap = 0; fail = 1'b0; nt = 0; nd = 0;
        if (!m) return;
        for (int t = 0; t <= MT; t++) begin
            nt = t + 1;
            if (t >= oa) begin fail = 1'b1; tap = t; return; end
            votes = (t >= la) ? WIN : ((t == ga) ? 1 : 0);
            if (votes >= THR) begin nd = (t < BK) ? t : BK; tap = t - nd; return; end
            if (t == MT) begin fail = 1'b1; tap = MT; return; end
        end
    endfunction

    // IOD + eye model: tracks line position from pulses and flags protocol violations.
    always @(negedge clk) begin
        logic [NL-1:0] lt, oo, ea;
        cyc++;
        if (!$onehot0(dif.DELAY_LINE_LOAD) || !$onehot0(dif.DELAY_LINE_MOVE) ||
            !$onehot0(dif.DELAY_LINE_DIRECTION) || !$onehot0(dif.EYE_MONITOR_CLEAR_FLAGS))
            viol++;
        for (int i = 0; i < NL; i++) begin
            if (dif.DELAY_LINE_LOAD[i]) begin
                if (cyc - last_lm[i] <= SC) viol++;
                n_load[i]++; pos[i] = 0; win_idx[i] = 0; last_lm[i] = cyc;
            end
            if (dif.DELAY_LINE_MOVE[i]) begin
                if (cyc - last_lm[i] <= SC) viol++;
                if (dif.DELAY_LINE_DIRECTION[i] != dir_prev[i]) viol++;
                if (dif.DELAY_LINE_DIRECTION[i]) begin n_inc[i]++; pos[i]++; end
                else begin n_dec[i]++; pos[i]--; end
                win_idx[i] = 0; last_lm[i] = cyc;
            end
            if (dif.EYE_MONITOR_CLEAR_FLAGS[i]) begin
                if (cyc - last_lm[i] <= SC) viol++;
                n_clr[i]++; win_idx[i]++;
            end
            dir_prev[i] = dif.DELAY_LINE_DIRECTION[i];
            lt[i] = (pos[i] >= late_a[i]) || (pos[i] == glitch_a[i] && win_idx[i] == 1);
            oo[i] = (pos[i] >= oor_a[i]);
            ea[i] = (pos[i] < late_a[i]);
        end
        dif.EYE_MONITOR_LATE        = lt;
        dif.DELAY_LINE_OUT_OF_RANGE = oo;
        dif.EYE_MONITOR_EARLY       = ea;
    end

    task automatic load_model(input vec_t v);
        for (int i = 0; i < NL; i++) begin
            late_a[i] = int'(v.late_at[i]); oor_a[i] = int'(v.oor_at[i]); glitch_a[i] = int'(v.glitch_at[i]);
            n_load[i] = 0; n_inc[i] = 0; n_dec[i] = 0; n_clr[i] = 0;
        end
        viol = 0;
    endtask

    task automatic run_vec(input vec_t v, input bit use_exp);
        int m_tap, m_nt, m_nd, k, act;
        bit m_fail;
        load_model(v);
        dif.LANE_MASK = v.mask; dif.START = 1'b1;
        @(negedge clk);
        dif.START = 1'b0; dif.LANE_MASK = NL'($urandom);
        chk({v.name, ".busy_after_start"}, int'(dif.BUSY), 1);
        if (v.noise) begin
            repeat (40) @(negedge clk);
            dif.LANE_MASK = '0; dif.START = 1'b1;
            @(negedge clk);
            dif.START = 1'b0;
        end
        k = 0;
        while (!dif.DONE && k < 60000) begin @(negedge clk); k++; end
        chk({v.name, ".done_seen"}, int'(dif.DONE), 1);
        chk({v.name, ".busy_low_at_done"}, int'(dif.BUSY), 0);
        dif.LANE_MASK = '1; dif.START = 1'b1;
        @(negedge clk);
        dif.START = 1'b0;
        chk({v.name, ".done_one_cycle"}, int'(dif.DONE), 0);
        @(negedge clk);
        chk({v.name, ".start_in_fin_ignored"}, int'(dif.BUSY), 0);
        for (int i = 0; i < NL; i++) begin
            model_lane(v.mask[i], late_a[i], oor_a[i], glitch_a[i], m_tap, m_fail, m_nt, m_nd);
            act = int'(dif.TAP_VALUE[i*TW +: TW]);
            chk($sformatf("%s.tap_l%0d", v.name, i), act, m_tap);
            chk($sformatf("%s.fail_l%0d", v.name, i), int'(dif.LANE_FAIL[i]), int'(m_fail));
            if (use_exp) begin
                chk($sformatf("%s.tap_tbl_l%0d", v.name, i), act, int'(v.exp_tap[i]));
                chk($sformatf("%s.fail_tbl_l%0d", v.name, i), int'(dif.LANE_FAIL[i]), int'(v.exp_fail[i]));
            end
            chk($sformatf("%s.loads_l%0d", v.name, i), n_load[i], int'(v.mask[i]));
            chk($sformatf("%s.inc_l%0d", v.name, i), n_inc[i], v.mask[i] ? m_nt - 1 : 0);
            chk($sformatf("%s.dec_l%0d", v.name, i), n_dec[i], m_nd);
            chk($sformatf("%s.clr_l%0d", v.name, i), n_clr[i], m_nt * WIN);
            if (v.mask[i]) chk($sformatf("%s.line_pos_l%0d", v.name, i), pos[i], m_tap);
        end
        chk({v.name, ".protocol"}, viol, 0);
    endtask

    function automatic vec_t mk(input string nm, input logic [NL-1:0] m,
                                input logic [NL-1:0][7:0] la, input logic [NL-1:0][7:0] oa,
                                input logic [NL-1:0][7:0] ga, input logic [NL-1:0][7:0] et,
                                input logic [NL-1:0] ef, input bit nz);
        vec_t v;
        v.name = nm; v.mask = m; v.late_at = la; v.oor_at = oa; v.glitch_at = ga;
        v.exp_tap = et; v.exp_fail = ef; v.noise = nz;
        return v;
    endfunction

    initial begin
        vec_t tbl[5];
        vec_t rv;
        logic [NL-1:0][7:0] nv;
        int k, snap;
        nv = '1;
        for (int i = 0; i < NL; i++) begin
            late_a[i] = NEVER; oor_a[i] = NEVER; glitch_a[i] = NEVER;
            pos[i] = 0; win_idx[i] = 0; last_lm[i] = -1000;
            n_load[i] = 0; n_inc[i] = 0; n_dec[i] = 0; n_clr[i] = 0;
        end
        tbl[0] = mk("edges", 4'b1111, {8'd60, 8'd0, 8'd35, 8'd20}, nv, nv,
                    {8'd56, 8'd0, 8'd31, 8'd16}, 4'b0000, 1'b1);
        tbl[1] = mk("no_late_l1", 4'b1111, {8'd60, 8'd0, 8'd255, 8'd20}, nv, nv,
                    {8'd56, 8'd0, 8'd127, 8'd16}, 4'b0010, 1'b0);
        tbl[2] = mk("oor_l0", 4'b1111, {8'd9, 8'd7, 8'd5, 8'd20}, {8'd255, 8'd255, 8'd255, 8'd10}, nv,
                    {8'd5, 8'd3, 8'd1, 8'd10}, 4'b0001, 1'b0);
        tbl[3] = mk("mask_0101", 4'b0101, {8'd60, 8'd0, 8'd35, 8'd20}, nv, nv,
                    {8'd0, 8'd0, 8'd0, 8'd16}, 4'b0000, 1'b0);
`ifdef DQSW_TRAIN_MAJORITY_EN
        tbl[4] = mk("glitch", 4'b1111, {8'd6, 8'd6, 8'd6, 8'd18}, nv, {8'd255, 8'd255, 8'd255, 8'd12},
                    {8'd2, 8'd2, 8'd2, 8'd14}, 4'b0000, 1'b0);
`else
        tbl[4] = mk("glitch", 4'b1111, {8'd6, 8'd6, 8'd6, 8'd18}, nv, {8'd255, 8'd255, 8'd255, 8'd12},
                    {8'd2, 8'd2, 8'd2, 8'd8}, 4'b0000, 1'b0);
`endif

        rst = 1'b1; dif.START = 1'b0; dif.LANE_MASK = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", int'(dif.BUSY), 0);
        chk("rst.done", int'(dif.DONE), 0);
        chk("rst.pulses", int'({dif.DELAY_LINE_LOAD, dif.DELAY_LINE_MOVE,
                                dif.DELAY_LINE_DIRECTION, dif.EYE_MONITOR_CLEAR_FLAGS}), 0);
        chk("rst.tap_value", int'(dif.TAP_VALUE), 0);
        chk("rst.lane_fail", int'(dif.LANE_FAIL), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) run_vec(tbl[t], 1'b1);

        // Abort mid-SAMPLE of lane 2, then train again from a fresh START.
        load_model(tbl[0]);
        dif.LANE_MASK = 4'b1111; dif.START = 1'b1;
        @(negedge clk);
        dif.START = 1'b0;
        k = 0;
        while (n_clr[2] == 0 && k < 20000) begin @(negedge clk); k++; end
        chk("abort.reached_lane2", int'(n_clr[2] > 0), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.busy", int'(dif.BUSY), 0);
        chk("abort.pulses", int'({dif.DELAY_LINE_LOAD, dif.DELAY_LINE_MOVE,
                                  dif.DELAY_LINE_DIRECTION, dif.EYE_MONITOR_CLEAR_FLAGS}), 0);
        chk("abort.tap_value", int'(dif.TAP_VALUE), 0);
        chk("abort.lane_fail", int'(dif.LANE_FAIL), 0);
        rst = 1'b0;
        snap = 0;
        for (int i = 0; i < NL; i++) snap += n_load[i] + n_inc[i] + n_dec[i] + n_clr[i];
        repeat (30) @(negedge clk);
        k = 0;
        for (int i = 0; i < NL; i++) k += n_load[i] + n_inc[i] + n_dec[i] + n_clr[i];
        chk("abort.no_more_pulses", k, snap);
        chk("abort.stays_idle", int'(dif.BUSY), 0);
        run_vec(tbl[0], 1'b1);

        for (int r = 0; r < 5; r++) begin
            rv.name = $sformatf("rand%0d", r);
            rv.mask = NL'($urandom);
            rv.noise = 1'b0; rv.exp_tap = '0; rv.exp_fail = '0;
            for (int i = 0; i < NL; i++) begin
                rv.late_at[i]   = 8'($urandom_range(0, 30));
                rv.oor_at[i]    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'd255;
                rv.glitch_at[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'd255;
            end
            run_vec(rv, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dqsw_delay_trainer.md
Name: dqsw_delay_trainer

Overview:
Parametrised multi-lane DQSW delay-line training controller. It drives the dynamic delay-line and eye-monitor controls of NUM_LANES DQSW training IODs and sweeps each lane's delay upward until the eye monitor reports LATE. It then backs off by a fixed margin and reports the final tap per lane. It sits in the DDR PHY block between the training sequencer (START/DONE handshake) and the per-lane IOD instances.

Parameters:
NUM_LANES, 4, number of DQSW lanes trained (1..16)
TAP_W, 7, width of tap counters / reported tap values
MAX_TAPS, 127, highest tap tried before declaring a lane failed (must fit in TAP_W)
SETTLE_CYCLES, 8, FAB_CLK cycles waited after each LOAD/MOVE pulse (>=1)
SAMPLE_CYCLES, 16, eye-monitor observation window per sample (>=1)
BACKOFF, 4, taps decremented after the edge is found

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
SYNC_RST  in  1  synchronous active-high reset
START  in  1  one-cycle request to begin training; ignored while BUSY=1
LANE_MASK  in  NUM_LANES  1 = train lane; sampled on accepted START
BUSY  out  1  high from the cycle after START is accepted until DONE
DONE  out  1  one-cycle pulse when all lanes are finished
LANE_FAIL  out  NUM_LANES  per-lane failure flag, valid from DONE until next START
TAP_VALUE  out  NUM_LANES*TAP_W  packed final taps; lane i at [i*TAP_W +: TAP_W]
DELAY_LINE_LOAD  out  NUM_LANES  one-cycle load pulse per lane
DELAY_LINE_MOVE  out  NUM_LANES  one-cycle move pulse per lane
DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment; held stable around MOVE
EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle flag-clear pulse
EYE_MONITOR_EARLY  in  NUM_LANES  per-lane eye-monitor early flag
EYE_MONITOR_LATE  in  NUM_LANES  per-lane eye-monitor late flag
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane delay-line overflow

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, LANE_FAIL/TAP_VALUE cleared. Reset during training aborts immediately, with no further pulses.
- There is one shared FSM with a lane index `lane`. Only the active lane's control bits toggle; the other lanes' bits stay 0.
- IDLE: on START=1, latch LANE_MASK, clear results, set lane=0, go to SELECT. BUSY rises the next cycle.
- SELECT: if mask[lane]=0, go to NEXT (lane result TAP=0, FAIL=0). Otherwise go to LOAD.
- LOAD: pulse DELAY_LINE_LOAD[lane] for 1 cycle, set tap=0, go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to CLEAR.
- CLEAR: pulse EYE_MONITOR_CLEAR_FLAGS[lane] for 1 cycle, go to SAMPLE.
- SAMPLE: for SAMPLE_CYCLES, sticky-OR EARLY, LATE and OUT_OF_RANGE of the lane. Then go to EVAL.
- EVAL (priority order):
  - OUT_OF_RANGE seen: set FAIL[lane]=1, TAP=tap, go to NEXT.
  - LATE seen: edge=tap, go to BACKOFF.
  - tap==MAX_TAPS: set FAIL[lane]=1, TAP=MAX_TAPS, go to NEXT.
  - Otherwise go to MOVE.
  - EARLY alone counts as not-edge.
- MOVE: DIRECTION=1 in the same cycle and the cycle before; MOVE pulses 1 cycle; tap++. Then go to SETTLE.
- BACKOFF: issue n=min(BACKOFF, edge) decrement pulses. Each pulse has DIRECTION=0 set one cycle ahead, and is followed by SETTLE_CYCLES of wait. Then TAP=edge-n, go to NEXT. If edge=0, no pulses are issued and TAP=0.
- NEXT: if lane==NUM_LANES-1, go to FIN; otherwise lane++ and go to SELECT.
- FIN: DONE=1 for 1 cycle, BUSY=0 in that same cycle, go to IDLE.
- tap never wraps; MAX_TAPS is a hard ceiling. Sticky flags are cleared on entry to SAMPLE.
- START while BUSY=1 is ignored. START in the FIN cycle is ignored; it is accepted from IDLE on the following cycle.
- Latency for one lane with its edge at tap k, counted in EVAL cycles: (k+1) EVALs. Each tap costs 1(MOVE/LOAD) + SETTLE_CYCLES + 1 + SAMPLE_CYCLES + 1 cycles.

Optional Feature:
DQSW_TRAIN_MAJORITY_EN
- Defined: each tap is sampled in 3 consecutive CLEAR+SAMPLE windows. LATE is taken as seen only if it is flagged in at least 2 of the 3 windows. OUT_OF_RANGE in any window is still fatal.
- Undefined: a single window per tap, and a single LATE flag marks the edge.

Test Plan:
1. NUM_LANES=4, mask=4'b1111, LATE model asserts at taps 20/35/0/60. Expected: DONE pulse, LANE_FAIL=0, TAP_VALUE={56,0,31,16}. Lane 2 shows no decrement MOVE pulses.
2. LATE never asserts on lane 1. Expected: lane 1 is swept to tap 127 with exactly 127 increment MOVEs, LANE_FAIL[1]=1, TAP=127, and the other lanes are unaffected.
3. OUT_OF_RANGE rises on lane 0 at tap 10. Expected: LANE_FAIL[0]=1, TAP=10, no BACKOFF pulses, and lane 1 training starts next.
4. mask=4'b0101. Expected: lanes 1 and 3 get zero LOAD/MOVE/CLEAR pulses, TAP=0, FAIL=0. DONE arrives after lanes 0 and 2 only.
5. SYNC_RST=1 during lane 2 SAMPLE. Expected: next cycle all outputs are 0, BUSY=0, results are cleared. A fresh START then completes normally. START pulses while BUSY do not restart training.
6. MAJORITY_EN with LATE glitching in a single window at tap 12 and solid from tap 18. Expected: edge=18, TAP=14. Without the macro: edge=12, TAP=8.
